// File: rtl/memory_access.sv
// Memory stage: word-addressed data memory, branch resolution and the MEM/WB register slice.
// Optional feature macro: MISALIGN_TRAP_EN (traps accesses whose byte offset is non-zero).
module memory_access #(
  parameter int ADDR_BITS     = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_BUS_WIDTH = 3,
  parameter int WB_BUS_WIDTH  = 2,
  parameter int MEM_DEPTH     = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic [MEM_BUS_WIDTH-1:0] memory_bus_in,
  input  logic [WB_BUS_WIDTH-1:0]  wb_bus_in,
  input  logic [DATA_WIDTH-1:0]    alu_result_in,
  input  logic [DATA_WIDTH-1:0]    reg_rt_data_in,
  input  logic [ADDR_BITS-1:0]     add_reg_w_in,
  input  logic [ADDR_BITS-1:0]     next_pc_in,
  input  logic                     alu_zero_flag_in,
  output logic                     pc_src_out,
  output logic [ADDR_BITS-1:0]     branch_target_out,
  output logic [DATA_WIDTH-1:0]    read_data_out,
  output logic [DATA_WIDTH-1:0]    alu_result_out,
  output logic [ADDR_BITS-1:0]     add_reg_w_out,
  output logic [WB_BUS_WIDTH-1:0]  wb_bus_out,
  output logic                     valid_out,
  output logic                     misalign_err_out
);

  localparam int IDX_BITS = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]   r_read_data;
  logic [DATA_WIDTH-1:0]   r_alu_result;
  logic [ADDR_BITS-1:0]    r_add_reg_w;
  logic [WB_BUS_WIDTH-1:0] r_wb_bus;
  logic                    r_valid;

  logic [IDX_BITS-1:0]     w_idx;
  logic                    w_mis;
  logic                    w_rd;
  logic                    w_wr;
  logic                    w_unused_bits;

  // Upper address bits drop out, so accesses wrap modulo MEM_DEPTH words.
  assign w_idx         = alu_result_in[IDX_BITS+1:2];
  assign w_unused_bits = ^{alu_result_in[DATA_WIDTH-1:IDX_BITS+2], alu_result_in[1:0]};

`ifdef MISALIGN_TRAP_EN
  logic r_misalign;

  assign w_mis = valid_in & (alu_result_in[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else if (w_mis) begin
      r_misalign <= 1'b1;
    end
  end

  assign misalign_err_out = r_misalign;
`else
  assign w_mis            = 1'b0;
  assign misalign_err_out = 1'b0;
`endif

  assign w_rd = valid_in & memory_bus_in[0] & ~w_mis;
  assign w_wr = valid_in & memory_bus_in[1] & ~w_mis;

  assign pc_src_out        = valid_in & memory_bus_in[2] & alu_zero_flag_in;
  assign branch_target_out = next_pc_in;

  // Memory is not reset; a store landing on an edge while reset is held is dropped.
  always_ff @(posedge clk) begin
    if (w_wr && rst_n) begin
      r_mem[w_idx] <= reg_rt_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read_data  <= '0;
      r_alu_result <= '0;
      r_add_reg_w  <= '0;
      r_wb_bus     <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_read_data  <= w_rd ? r_mem[w_idx] : '0;
      r_alu_result <= alu_result_in;
      r_add_reg_w  <= add_reg_w_in;
      r_wb_bus     <= (valid_in && !w_mis) ? wb_bus_in : '0;
      r_valid      <= valid_in;
    end
  end

  assign read_data_out  = r_read_data;
  assign alu_result_out = r_alu_result;
  assign add_reg_w_out  = r_add_reg_w;
  assign wb_bus_out     = r_wb_bus;
  assign valid_out      = r_valid;

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 32, the width of the address, PC and register-address buses.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, the data word width.
REQ-003 The block SHALL have parameter MEM_BUS_WIDTH, default 3, the memory control bus width: bit0 mem_read, bit1 mem_write, bit2 branch.
REQ-004 The block SHALL have parameter WB_BUS_WIDTH, default 2, the writeback control bus width, passed through opaque.
REQ-005 The block SHALL have parameter MEM_DEPTH, default 256, the number of data-memory words; it SHALL be a power of 2.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-007 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 Port valid_in, input, 1 bit: the incoming execute-stage instruction is valid.
REQ-009 Port memory_bus_in, input, MEM_BUS_WIDTH: memory control from execute.
REQ-010 Port wb_bus_in, input, WB_BUS_WIDTH: writeback control from execute.
REQ-011 Port alu_result_in, input, DATA_WIDTH: the ALU result, used as the byte address.
REQ-012 Port reg_rt_data_in, input, DATA_WIDTH: the store data.
REQ-013 Port add_reg_w_in, input, ADDR_BITS: the destination register address.
REQ-014 Port next_pc_in, input, ADDR_BITS: the branch target computed in execute.
REQ-015 Port alu_zero_flag_in, input, 1 bit: the ALU zero flag.
REQ-016 Port pc_src_out, output, 1 bit: take-branch select to fetch (combinational).
REQ-017 Port branch_target_out, output, ADDR_BITS: the branch target to fetch (combinational).
REQ-018 Port read_data_out, output, DATA_WIDTH: the registered load data.
REQ-019 Port alu_result_out, output, DATA_WIDTH: the registered ALU result.
REQ-020 Port add_reg_w_out, output, ADDR_BITS: the registered destination register address.
REQ-021 Port wb_bus_out, output, WB_BUS_WIDTH: the registered writeback control.
REQ-022 Port valid_out, output, 1 bit: the registered valid flag.
REQ-023 Port misalign_err_out, output, 1 bit: sticky misaligned-access flag.

Function
REQ-024 Word index SHALL be alu_result_in[log2(MEM_DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo MEM_DEPTH*4.
REQ-025 An access is active only when valid_in=1; with valid_in=0 there SHALL be no memory write and no branch.
REQ-026 pc_src_out SHALL equal valid_in & memory_bus_in[2] & alu_zero_flag_in.
REQ-027 branch_target_out SHALL equal next_pc_in.
REQ-028 On an active write (bit1=1), mem[index] SHALL be loaded with reg_rt_data_in at the rising edge.
REQ-029 read_data_out SHALL register mem[index] at the same edge when active and bit0=1, and SHALL load 0 otherwise; load-to-output latency SHALL be 1 cycle.
REQ-030 When read and write are both set, read_data_out SHALL return the pre-write contents (read-before-write).
REQ-031 A load in cycle N+1 from the address stored in cycle N SHALL return the new data; no bypass is needed.
REQ-032 Every cycle, alu_result_out, add_reg_w_out and valid_out SHALL register their inputs (valid_out <= valid_in).
REQ-033 Every cycle, wb_bus_out SHALL register wb_bus_in when valid_in=1 and 0 otherwise.

Reset
REQ-034 While rst_n=0, all registered outputs SHALL be 0 immediately, independent of clk.
REQ-035 Memory contents SHALL NOT be reset.
REQ-036 A write coincident with reset assertion SHALL be discarded.
REQ-037 After rst_n deasserts, the first rising edge SHALL operate normally.

Configuration
REQ-038 Macro MISALIGN_TRAP_EN, when defined, SHALL flag an active access with alu_result_in[1:0]!=0 as misaligned.
REQ-039 With MISALIGN_TRAP_EN defined, a misaligned access SHALL suppress the write, force read_data_out=0 and wb_bus_out=0, and set misalign_err_out=1 until reset.
REQ-040 With MISALIGN_TRAP_EN undefined, alu_result_in[1:0] SHALL be ignored and misalign_err_out SHALL be tied to 0.

Verification
REQ-041 Store 0xDEADBEEF at addr 0x10, load 0x10 next cycle -> read_data_out=0xDEADBEEF one cycle after the load, with wb_bus_out and valid_out=1 alongside.
REQ-042 Read+write at 0x20 (old 0x1, new 0x2) -> read_data_out=0x1, and a following load returns 0x2.
REQ-043 Branch=1, zero=1, valid=1, next_pc=0x400 -> pc_src_out=1 and branch_target_out=0x400 in the same cycle; with zero=0 -> pc_src_out=0.
REQ-044 Store at 0x400 with MEM_DEPTH=256 -> a load at 0x0 returns the stored data (wrap).
REQ-045 rst_n pulsed low mid-stream between edges -> all outputs 0 immediately; data written earlier is still readable afterwards.
REQ-046 With MISALIGN_TRAP_EN defined, store at 0x13 -> mem unchanged, misalign_err_out=1 and sticky until reset; with it undefined, the store lands at index 4.
